axi_b_channel_tap: RTL and testbench
====================================

# axi_b_channel_tap

Parametrised AXI write-response (B) channel tap that sits between the downstream AXI master port and the upstream AXI slave port, passing B responses through. It captures every completed B handshake into a FIFO and streams each capture as a multi-beat record on the shared stream output, where an external arbiter grants access through `ready`. It also adds a sequence number and a compile-time choice between lossless back-pressure and a non-intrusive drop-on-full mode.

## Interface
Parameters:
- `DATA_WIDTH`, 128, stream beat width.
- `ID_WIDTH`, 32, AXI BID width.
- `USER_WIDTH`, 64, AXI BUSER width.
- `SEQ_WIDTH`, 16, sequence counter width.
- `FIFO_DEPTH`, 8, capture FIFO entries; power of two, ≥2.
- Derived: `REC_W` = SEQ_WIDTH+USER_WIDTH+2+ID_WIDTH; `BEATS` = ceil(REC_W/DATA_WIDTH).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `ready`  in  1  arbiter grant/accept; a beat transfers when `valid && ready`.
- `valid`  out  1  this block has a beat to stream.
- `in_progress`  out  1  packet ownership of the stream; blocks other submodules.
- `last`  out  1  final beat of the current record.
- `data`  out  DATA_WIDTH  beat payload.
- `AXIM_bid`  in  ID_WIDTH; `AXIM_bresp`  in  2; `AXIM_buser`  in  USER_WIDTH; `AXIM_bvalid`  in  1. Downstream B response.
- `AXIM_bready`  out  1  to downstream.
- `AXIS_bid`  out  ID_WIDTH; `AXIS_bresp`  out  2; `AXIS_buser`  out  USER_WIDTH; `AXIS_bvalid`  out  1. Upstream B response.
- `AXIS_bready`  in  1  from upstream.

## Operation
- B path: bid/bresp/buser are combinational pass-through. Valid/ready gating is set in Configuration.
- Capture event: `AXIS_bvalid && AXIS_bready`, the upstream handshake.
- On a capture event, the record is pushed when the FIFO is not full. Record layout, LSB first: [ID_WIDTH-1:0] bid, then 2 bits bresp, then USER_WIDTH bits buser, then SEQ_WIDTH bits seq.
- `seq` is incremented on every capture event, pushed or dropped. It wraps modulo 2^SEQ_WIDTH. The pushed value is the pre-increment count; the first record after reset carries seq=0.
- Stream: the record is split into BEATS slices of DATA_WIDTH bits, lowest slice first. The final slice is zero-padded above REC_W.
- FSM IDLE/STREAM, with beat index `bidx`:
  - IDLE: `valid` = FIFO not empty; `data` = slice 0 of the head record.
  - IDLE, on `valid && ready`: if BEATS==1, pop the head and stay in IDLE. Otherwise set bidx=1 and go to STREAM.
  - STREAM: `valid`=1; `data` = slice bidx. Each accepted beat increments bidx.
  - STREAM, on the accepted beat with bidx==BEATS-1: pop the head and return to IDLE.
- `ready` low stalls the FSM; `data` is held stable.
- `last` = `valid` && (beat index == BEATS-1).
- `in_progress` = (IDLE && valid && ready) || STREAM. It drops in the cycle after the last beat is accepted.
- `data`=0 whenever `valid`=0.
- FIFO full/empty are derived from a registered count of width clog2(FIFO_DEPTH)+1.

## Timing
- Reset (`resetn`=0 at a clock edge): FIFO emptied; seq=0; FSM=IDLE; bidx=0. `valid`, `in_progress`, `last` and `data` are 0 from the next cycle.
- Pass-through AXIS_b* outputs and `AXIM_bready` follow their inputs combinationally, including during reset.
- A reset asserted mid-packet abandons the record; no partial continuation.
- Capture-to-`valid` latency: 1 cycle when the FIFO was empty.
- Full is the registered state. A push while full is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop while not full: count unchanged; both take effect.
- Back-to-back records: the next record's beat 0 may be accepted in the cycle after the previous `last` beat, giving 1 record per BEATS cycles at full `ready`.

## Configuration
- `B_TAP_BACKPRESSURE_EN` defined (lossless mode):
  - `AXIS_bvalid` = `AXIM_bvalid && !full`.
  - `AXIM_bready` = `AXIS_bready && !full`.
  - No capture event occurs while full, so the seq stream is gap-free.
- Not defined (drop mode):
  - `AXIS_bvalid` = `AXIM_bvalid`; `AXIM_bready` = `AXIS_bready`. The tap never stalls the AXI path.
  - Captures while full are dropped; the resulting seq gaps reveal the drop count.

## Test plan
- Single response: defaults; bid=0x5, bresp=2'b10, buser=0xAB, ready=1. Expect one beat with last=1, data[31:0]=5, data[33:32]=2, data[97:34]=0xAB, seq field=0.
- Multi-beat: DATA_WIDTH=64 (BEATS=2); hold ready=0 for 3 cycles, then 1. Expect valid high, data stable at slice 0, in_progress=0 while stalled. Then 2 beats, last only on beat 2, and in_progress high across both.
- Drop mode, full: FIFO_DEPTH=4, ready=0, 6 B handshakes. AXIM_bready tracks AXIS_bready throughout. Once ready=1, expect 4 records with seq 0,1,2,3; the next capture carries seq=6.
- Back-pressure mode, full: same stimulus with `B_TAP_BACKPRESSURE_EN` defined. Expect AXIS_bvalid=0 and AXIM_bready=0 after 4 captures. After draining, expect seq 0..5 contiguous.
- Reset mid-packet: BEATS=2; assert resetn=0 after beat 0 is accepted. Next cycle expect valid=0, in_progress=0, FIFO empty; the next capture carries seq=0.
- Seq wrap: SEQ_WIDTH=4, 17 captures. Expect the record seq sequence 0..15, then 0.

Source files
------------

// File: rtl/axi_b_channel_tap.sv
// AXI B-channel tap: passes write responses through and streams each completed
// handshake as a sequenced multi-beat record. Define B_TAP_BACKPRESSURE_EN for lossless mode.
module axi_b_channel_tap #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64,
  parameter int SEQ_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ready,
  output logic                  valid,
  output logic                  in_progress,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] data,
  input  logic [ID_WIDTH-1:0]   AXIM_bid,
  input  logic [1:0]            AXIM_bresp,
  input  logic [USER_WIDTH-1:0] AXIM_buser,
  input  logic                  AXIM_bvalid,
  output logic                  AXIM_bready,
  output logic [ID_WIDTH-1:0]   AXIS_bid,
  output logic [1:0]            AXIS_bresp,
  output logic [USER_WIDTH-1:0] AXIS_buser,
  output logic                  AXIS_bvalid,
  input  logic                  AXIS_bready
);

  localparam int REC_W  = SEQ_WIDTH + USER_WIDTH + 2 + ID_WIDTH;
  localparam int BEATS  = (REC_W + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  // Stream handshake: a beat moves on a cycle where valid && ready; while
  // ready is low, valid and data hold their values.

  logic [REC_W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [SEQ_WIDTH-1:0]     seq;
  logic [0:0]               state;
  logic [BIDX_W-1:0]        bidx;
  logic [BIDX_W-1:0]        cur_bidx;
  logic [BEATS*DATA_WIDTH-1:0] rec_pad;
  logic                     full, empty, cap, push, accept, pop;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign AXIS_bid   = AXIM_bid;
  assign AXIS_bresp = AXIM_bresp;
  assign AXIS_buser = AXIM_buser;
`ifdef B_TAP_BACKPRESSURE_EN
  assign AXIS_bvalid = AXIM_bvalid && !full;
  assign AXIM_bready = AXIS_bready && !full;
`else
  assign AXIS_bvalid = AXIM_bvalid;
  assign AXIM_bready = AXIS_bready;
`endif

  assign cap  = AXIS_bvalid && AXIS_bready;
  assign push = cap && !full;

  // In IDLE the head record is offered from beat 0 without a state change.
  assign cur_bidx    = (state == STREAM) ? bidx : '0;
  assign valid       = (state == STREAM) || !empty;
  assign last        = valid && (cur_bidx == BIDX_W'(BEATS - 1));
  assign accept      = valid && ready;
  assign pop         = accept && last;
  assign in_progress = ((state == IDLE) && accept) || (state == STREAM);

  always_comb begin
    rec_pad = '0;
    rec_pad[REC_W-1:0] = mem[rd_ptr];
    data = '0;
    if (valid) data = rec_pad[int'(cur_bidx) * DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= {seq, AXIM_buser, AXIM_bresp, AXIM_bid};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
      state  <= IDLE;
      bidx   <= '0;
    end else begin
      // Sequence advances on every capture so drops show up as gaps.
      if (cap)  seq    <= seq + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (accept) begin
        if (last) begin
          state <= IDLE;
          bidx  <= '0;
        end else begin
          state <= STREAM;
          bidx  <= cur_bidx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_b_channel_tap.sv
// Bench for axi_b_channel_tap: directed phases then random traffic, checked
// every cycle against a queue-of-records reference model.
module tb_axi_b_channel_tap;

  localparam int DW    = 64;
  localparam int IW    = 32;
  localparam int UW    = 64;
  localparam int SW    = 4;
  localparam int DEPTH = 4;
  localparam int REC_W = SW + UW + 2 + IW;
  localparam int BEATS = (REC_W + DW - 1) / DW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ready;
  logic          valid, in_progress, last;
  logic [DW-1:0] data;
  logic [IW-1:0] AXIM_bid, AXIS_bid;
  logic [1:0]    AXIM_bresp, AXIS_bresp;
  logic [UW-1:0] AXIM_buser, AXIS_buser;
  logic          AXIM_bvalid, AXIM_bready, AXIS_bvalid, AXIS_bready;

  axi_b_channel_tap #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .SEQ_WIDTH(SW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .ready(ready), .valid(valid),
    .in_progress(in_progress), .last(last), .data(data),
    .AXIM_bid(AXIM_bid), .AXIM_bresp(AXIM_bresp), .AXIM_buser(AXIM_buser),
    .AXIM_bvalid(AXIM_bvalid), .AXIM_bready(AXIM_bready),
    .AXIS_bid(AXIS_bid), .AXIS_bresp(AXIS_bresp), .AXIS_buser(AXIS_buser),
    .AXIS_bvalid(AXIS_bvalid), .AXIS_bready(AXIS_bready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  string       phase  = "init";
  logic [REC_W-1:0] exp_q[$];
  int          seq_m = 0;
  int          mb    = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive(input logic bv, input logic br, input logic rdy);
    AXIM_bvalid = bv;
    AXIS_bready = br;
    ready       = rdy;
    AXIM_bid    = $urandom;
    AXIM_bresp  = 2'($urandom_range(0, 3));
    AXIM_buser  = {$urandom, $urandom};
  endtask

  // Checks outputs against the model, then advances the model across one edge.
  task automatic cycle();
    logic full_m, exp_bv, exp_br, exp_valid, exp_last, exp_ip, cap, acc;
    logic [BEATS*DW-1:0] pad;
    logic [DW-1:0]       exp_data;
    logic [REC_W-1:0]    new_rec;
    #1;
    full_m = (exp_q.size() == DEPTH);
`ifdef B_TAP_BACKPRESSURE_EN
    exp_bv = AXIM_bvalid && !full_m;
    exp_br = AXIS_bready && !full_m;
`else
    exp_bv = AXIM_bvalid;
    exp_br = AXIS_bready;
`endif
    exp_valid = (exp_q.size() != 0);
    pad = '0;
    exp_data = '0;
    if (exp_valid) begin
      pad[REC_W-1:0] = exp_q[0];
      exp_data = pad[mb*DW +: DW];
    end
    exp_last = exp_valid && (mb == BEATS - 1);
    acc      = exp_valid && ready;
    exp_ip   = (mb != 0) || acc;
    cap      = exp_bv && AXIS_bready;
    new_rec  = {SW'(seq_m), AXIM_buser, AXIM_bresp, AXIM_bid};

    check("bid",         AXIS_bid,    AXIM_bid);
    check("bresp",       AXIS_bresp,  AXIM_bresp);
    check("buser",       AXIS_buser,  AXIM_buser);
    check("axis_bvalid", AXIS_bvalid, exp_bv);
    check("axim_bready", AXIM_bready, exp_br);
    check("valid",       valid,       exp_valid);
    check("last",        last,        exp_last);
    check("in_progress", in_progress, exp_ip);
    check("data",        data,        exp_data);

    @(posedge clk);
    if (!resetn) begin
      exp_q.delete();
      seq_m = 0;
      mb    = 0;
    end else begin
      if (acc) begin
        if (mb == BEATS - 1) begin
          void'(exp_q.pop_front());
          mb = 0;
        end else begin
          mb++;
        end
      end
      if (cap && !full_m) exp_q.push_back(new_rec);
      if (cap) seq_m = (seq_m + 1) % (1 << SW);
    end
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    phase = "reset";
    cycle();
    resetn = 1'b1;
    cycle();

    phase = "single";
    drive(1'b1, 1'b1, 1'b1);
    AXIM_bid = 32'h5; AXIM_bresp = 2'b10; AXIM_buser = 64'hAB;
    cycle();
    drive(1'b0, 1'b1, 1'b1);
    repeat (4) cycle();

    phase = "stall";
    drive(1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) cycle();
    drive(1'b0, 1'b1, 1'b1);
    repeat (3) cycle();

    phase = "full";
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b1);
    repeat (12) cycle();
    drive(1'b1, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 1'b1);
    repeat (4) cycle();

    phase = "reset_mid";
    drive(1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b1);
    cycle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();
    drive(1'b1, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 1'b1);
    repeat (4) cycle();

    phase = "wrap";
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      cycle();
      drive(1'b0, 1'b1, 1'b1);
      cycle();
    end
    repeat (4) cycle();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      resetn = ($urandom_range(0, 49) != 0);
      cycle();
    end
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    repeat (12) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
